// File: rtl/fft_frame_serializer_if.sv
// Frame-in / sample-out bundle for the FFT frame serializer.
// Frame side is fed by the FFT core; sample side is a valid/ready stream.
interface fft_frame_serializer_if #(
    parameter int DATA_W = 50,
    parameter int N      = 8,
    parameter int IDX_W  = $clog2(N)
);
    logic [N-1:0][DATA_W-1:0] frame_i;
    logic                     frame_valid_i;
    logic                     frame_ready_o;
    logic [DATA_W-1:0]        sample_o;
    logic                     sample_valid_o;
    logic                     sample_ready_i;
    logic [IDX_W-1:0]         sample_idx_o;
    logic                     sample_last_o;
    logic                     overrun_o;
    logic [7:0]               overrun_cnt_o;

    modport slave (
        input  frame_i,
        input  frame_valid_i,
        input  sample_ready_i,
        output frame_ready_o,
        output sample_o,
        output sample_valid_o,
        output sample_idx_o,
        output sample_last_o,
        output overrun_o,
        output overrun_cnt_o
    );

    modport master (
        output frame_i,
        output frame_valid_i,
        output sample_ready_i,
        input  frame_ready_o,
        input  sample_o,
        input  sample_valid_o,
        input  sample_idx_o,
        input  sample_last_o,
        input  overrun_o,
        input  overrun_cnt_o
    );
endinterface

// File: rtl/fft_frame_serializer.sv
// Ping-pong buffered serializer: N-lane FFT frames out as one sample per
// transfer, optionally bit-reversed into natural order; overflow drops frames.
module fft_frame_serializer #(
    parameter int DATA_W      = 50,
    parameter int N           = 8,
    parameter int BIT_REVERSE = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fft_frame_serializer_if.slave bus
);
    localparam int IDX_W = $clog2(N);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } occ_e;

    typedef logic [N-1:0][DATA_W-1:0] frame_t;

    occ_e             state_q, state_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0] k_q, k_d;
    frame_t           buf_q [2];
    frame_t           buf_d [2];
    logic             overrun_q, overrun_d;
    logic [7:0]       ovr_cnt_q, ovr_cnt_d;

    logic             valid;
    logic             ready;
    logic             k_last;
    logic             cap;
    logic             drop;
    logic             xfer;
    logic             pop;
    logic [IDX_W-1:0] lane;

    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        for (int i = 0; i < IDX_W; i++) begin
            r[i] = v[IDX_W-1-i];
        end
        return r;
    endfunction

    // Handshake qualifiers and read lane, all derived from registered state.
    always_comb begin
        valid  = (state_q != S_EMPTY);
        ready  = (state_q != S_FULL);
        k_last = (k_q == IDX_W'(N - 1));
        cap    = bus.frame_valid_i & ready;
        drop   = bus.frame_valid_i & ~ready;
        xfer   = valid & bus.sample_ready_i;
        pop    = xfer & k_last;
        lane   = (BIT_REVERSE != 0) ? bitrev(k_q) : k_q;
    end

    // Output port drive; no path from any input to any output.
    always_comb begin
        bus.frame_ready_o  = ready;
        bus.sample_valid_o = valid;
        bus.sample_o       = buf_q[rd_ptr_q][lane];
        bus.sample_idx_o   = k_q;
        bus.sample_last_o  = valid & k_last;
        bus.overrun_o      = overrun_q;
        bus.overrun_cnt_o  = ovr_cnt_q;
    end

    // Next-state: capture, stream position, occupancy and overrun tracking.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        k_d       = k_q;
        buf_d     = buf_q;
        overrun_d = drop;
        ovr_cnt_d = ovr_cnt_q;

        if (cap) begin
            buf_d[wr_ptr_q] = bus.frame_i;
            wr_ptr_d        = ~wr_ptr_q;
        end

        if (xfer) begin
            if (k_last) begin
                k_d      = '0;
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                k_d = k_q + 1'b1;
            end
        end

        unique case (state_q)
            S_EMPTY: begin
                if (cap) state_d = S_ONE;
            end
            S_ONE: begin
                if (cap && !pop) state_d = S_FULL;
                else if (pop && !cap) state_d = S_EMPTY;
            end
            S_FULL: begin
                if (pop) state_d = S_ONE;
            end
            default: state_d = S_EMPTY;
        endcase

        if (drop && ovr_cnt_q != 8'hFF) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
    end

    // Occupancy FSM and datapath registers; reset discards all buffered data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_EMPTY;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            k_q       <= '0;
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
            overrun_q <= 1'b0;
            ovr_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            k_q       <= k_d;
            buf_q[0]  <= buf_d[0];
            buf_q[1]  <= buf_d[1];
            overrun_q <= overrun_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end
endmodule

// File: tb/tb_fft_frame_serializer.sv
// Directed bench for fft_frame_serializer: bit-reversed and natural order,
// backpressure, overrun, back-to-back frames and mid-stream reset.
module tb_fft_frame_serializer;
    localparam int DATA_W = 50;
    localparam int N      = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [2:0] rev [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    always #5 clk_i = ~clk_i;

    fft_frame_serializer_if #(.DATA_W(DATA_W), .N(N)) ifr ();
    fft_frame_serializer_if #(.DATA_W(DATA_W), .N(N)) ifn ();

    assign ifn.frame_i        = ifr.frame_i;
    assign ifn.frame_valid_i  = ifr.frame_valid_i;
    assign ifn.sample_ready_i = ifr.sample_ready_i;

    fft_frame_serializer #(.DATA_W(DATA_W), .N(N), .BIT_REVERSE(1)) dut_r (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (ifr.slave)
    );

    fft_frame_serializer #(.DATA_W(DATA_W), .N(N), .BIT_REVERSE(0)) dut_n (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (ifn.slave)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input int tag);
        for (int j = 0; j < N; j++) begin
            ifr.frame_i[j] = DATA_W'(tag * 16 + j);
        end
    endtask

    function automatic logic [63:0] rval(input int tag, input int k);
        return 64'(tag * 16 + int'(rev[k]));
    endfunction

    initial begin
        int p;
        int it;
        ifr.frame_valid_i  = 1'b0;
        ifr.sample_ready_i = 1'b0;
        load(0);
        #1;
        check("rst_valid", 64'(ifr.sample_valid_o), 64'd0);
        check("rst_sample", 64'(ifr.sample_o), 64'd0);
        check("rst_idx", 64'(ifr.sample_idx_o), 64'd0);
        check("rst_last", 64'(ifr.sample_last_o), 64'd0);
        check("rst_ovr", 64'(ifr.overrun_o), 64'd0);
        check("rst_fready", 64'(ifr.frame_ready_o), 64'd1);
        step();
        rst_i = 1'b1;
        step();

        // 1 and 2: one frame, lanes 0..7, ready held high
        load(0);
        ifr.frame_valid_i  = 1'b1;
        ifr.sample_ready_i = 1'b1;
        check("t1_pre_valid", 64'(ifr.sample_valid_o), 64'd0);
        step();
        ifr.frame_valid_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("t1_valid", 64'(ifr.sample_valid_o), 64'd1);
            check("t1_sample", 64'(ifr.sample_o), rval(0, i));
            check("t1_idx", 64'(ifr.sample_idx_o), 64'(i));
            check("t1_last", 64'(ifr.sample_last_o), 64'(i == N - 1));
            check("t2_sample", 64'(ifn.sample_o), 64'(i));
            check("t2_idx", 64'(ifn.sample_idx_o), 64'(i));
            step();
        end
        check("t1_done", 64'(ifr.sample_valid_o), 64'd0);
        check("t2_done", 64'(ifn.sample_valid_o), 64'd0);

        // 3: ready toggling 1,0,1,0...
        load(2);
        ifr.frame_valid_i = 1'b1;
        step();
        ifr.frame_valid_i = 1'b0;
        p  = 0;
        it = 0;
        while (p < N && it < 40) begin
            ifr.sample_ready_i = (it % 2 == 0);
            check("t3_valid", 64'(ifr.sample_valid_o), 64'd1);
            check("t3_sample", 64'(ifr.sample_o), rval(2, p));
            check("t3_idx", 64'(ifr.sample_idx_o), 64'(p));
            if (ifr.sample_ready_i) p++;
            it++;
            step();
        end
        check("t3_xfers", 64'(p), 64'(N));
        check("t3_cycles", 64'(it), 64'd15);
        check("t3_done", 64'(ifr.sample_valid_o), 64'd0);

        // 4: ready low, frames A,B,C back to back; C dropped
        ifr.sample_ready_i = 1'b0;
        ifr.frame_valid_i  = 1'b1;
        load(4);
        step();
        check("t4_rdy_a", 64'(ifr.frame_ready_o), 64'd1);
        load(5);
        step();
        check("t4_rdy_b", 64'(ifr.frame_ready_o), 64'd0);
        check("t4_ovr_pre", 64'(ifr.overrun_o), 64'd0);
        load(6);
        step();
        ifr.frame_valid_i = 1'b0;
        check("t4_ovr", 64'(ifr.overrun_o), 64'd1);
        check("t4_cnt", 64'(ifr.overrun_cnt_o), 64'd1);
        step();
        check("t4_ovr_end", 64'(ifr.overrun_o), 64'd0);
        check("t4_cnt_hold", 64'(ifr.overrun_cnt_o), 64'd1);
        ifr.sample_ready_i = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            check("t4_valid", 64'(ifr.sample_valid_o), 64'd1);
            check("t4_sample", 64'(ifr.sample_o),
                  rval(i < N ? 4 : 5, i % N));
            check("t4_last", 64'(ifr.sample_last_o), 64'(i % N == N - 1));
            step();
        end
        check("t4_done", 64'(ifr.sample_valid_o), 64'd0);

        // 5: B captured on the same edge as A's last transfer
        load(7);
        ifr.frame_valid_i = 1'b1;
        step();
        ifr.frame_valid_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("t5_a_sample", 64'(ifr.sample_o), rval(7, i));
            if (i == N - 1) begin
                load(8);
                ifr.frame_valid_i = 1'b1;
            end
            step();
        end
        ifr.frame_valid_i = 1'b0;
        check("t5_b_valid", 64'(ifr.sample_valid_o), 64'd1);
        check("t5_b_idx", 64'(ifr.sample_idx_o), 64'd0);
        check("t5_fready", 64'(ifr.frame_ready_o), 64'd1);
        for (int i = 0; i < N; i++) begin
            check("t5_b_sample", 64'(ifr.sample_o), rval(8, i));
            step();
        end
        check("t5_done", 64'(ifr.sample_valid_o), 64'd0);

        // 6: reset mid-frame at k=3
        load(9);
        ifr.frame_valid_i = 1'b1;
        step();
        ifr.frame_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t6_a_sample", 64'(ifr.sample_o), rval(9, i));
            step();
        end
        check("t6_idx3", 64'(ifr.sample_idx_o), 64'd3);
        #2;
        rst_i = 1'b0;
        #1;
        check("t6_valid", 64'(ifr.sample_valid_o), 64'd0);
        check("t6_sample", 64'(ifr.sample_o), 64'd0);
        check("t6_idx", 64'(ifr.sample_idx_o), 64'd0);
        check("t6_last", 64'(ifr.sample_last_o), 64'd0);
        check("t6_fready", 64'(ifr.frame_ready_o), 64'd1);
        check("t6_cnt", 64'(ifr.overrun_cnt_o), 64'd0);
        step();
        step();
        rst_i = 1'b1;
        check("t6_post_valid", 64'(ifr.sample_valid_o), 64'd0);
        load(10);
        ifr.frame_valid_i = 1'b1;
        step();
        ifr.frame_valid_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("t6_d_sample", 64'(ifr.sample_o), rval(10, i));
            check("t6_d_idx", 64'(ifr.sample_idx_o), 64'(i));
            step();
        end
        check("t6_done", 64'(ifr.sample_valid_o), 64'd0);
        check("t6_cnt_end", 64'(ifr.overrun_cnt_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
